led_seq_ctrl: RTL and testbench

Pattern sequencer that drives the 8-bit board LED register. It owns the LED shift/toggle datapath and sequences it through four display modes (off, fill, shift, blink). A push-button input selects the next mode; an internal prescaler sets the update rate. It sits between the board button/switch inputs and the LED pins, replacing direct switch control of the LED register.

---
 rtl/led_seq_pkg.sv | 34 +++
 rtl/led_seq_ctrl_tick_gen.sv | 34 +++
 rtl/led_seq_ctrl.sv | 59 +++++
 tb/tb_led_seq_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared mode encodings, entry patterns and small helpers for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    localparam logic [7:0] PAT_OFF   = 8'h00;
    localparam logic [7:0] PAT_FILL  = 8'h00;
    localparam logic [7:0] PAT_SHIFT = 8'h80;
    localparam logic [7:0] PAT_BLINK = 8'h55;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:   return MODE_FILL;
            MODE_FILL:  return MODE_SHIFT;
            MODE_SHIFT: return MODE_BLINK;
            default:    return MODE_OFF;
        endcase
    endfunction

    function automatic logic [7:0] entry_pat(input mode_t m);
        case (m)
            MODE_OFF:   return PAT_OFF;
            MODE_FILL:  return PAT_FILL;
            MODE_SHIFT: return PAT_SHIFT;
            default:    return PAT_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Update-rate prescaler: registered one-cycle strobe every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // clr beats counting; a disabled cycle holds the count and emits nothing
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: button edge detector, mode register and LED update mux.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       pause,
    output logic [7:0] LED,
    output logic [1:0] mode,
    output logic       tick
);
    logic       btn_prev;
    logic       btn_edge;
    mode_t      mode_q, mode_d;
    logic [7:0] led_d;

    assign btn_edge = btn_next & ~btn_prev;
    assign mode     = mode_q;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (~pause),
        .clr  (btn_edge),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        btn_prev <= btn_next;
        if (rst) begin
            mode_q <= MODE_OFF;
            LED    <= PAT_OFF;
        end else begin
            mode_q <= mode_d;
            LED    <= led_d;
        end
    end

    // A button edge outranks a pending tick: the tick's update is dropped.
    always_comb begin
        mode_d = mode_q;
        led_d  = LED;
        if (btn_edge) begin
            mode_d = next_mode(mode_q);
            led_d  = entry_pat(next_mode(mode_q));
        end else if (tick) begin
            case (mode_q)
                MODE_OFF:   led_d = PAT_OFF;
                MODE_FILL:  led_d = (LED == 8'hFF) ? 8'h00 : {1'b1, LED[7:1]};
                MODE_SHIFT: led_d = (LED == 8'h01 || LED == 8'h00) ? 8'h80 : (LED >> 1);
                default:    led_d = ~LED;
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboarded bench: a step-index reference model predicts LED/mode/tick per clock edge.
module tb_led_seq_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] LED;
    logic [1:0] mode;
    logic       tick;

    led_seq_ctrl #(.TICK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .pause    (pause),
        .LED      (LED),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Model: mode number, position within that mode's repeating pattern, cycles since last tick.
    int   mm = 0, ms = 0, mc = 0;
    logic mt = 1'b0, mbp = 1'b0;
    logic [10:0] exp_q[$];
    int   total = 0, bad = 0, ncyc = 0;

    function automatic logic [7:0] model_led();
        logic [15:0] fill;
        fill = 16'hFF00 >> ms;
        case (mm)
            1:       return fill[7:0];
            2:       return 8'h80 >> ms;
            3:       return (ms == 1) ? 8'hAA : 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int period(input int m);
        case (m)
            1:       return 9;
            2:       return 8;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic cyc(input logic r, input logic b, input logic p);
        logic e, nt;
        @(negedge clk);
        rst = r; btn_next = b; pause = p;
        if (r) begin
            mm = 0; ms = 0; mc = 0; mt = 1'b0;
        end else begin
            e  = b & ~mbp;
            nt = 1'b0;
            if (e) mc = 0;
            else if (!p) begin
                if (mc == D - 1) begin mc = 0; nt = 1'b1; end
                else mc++;
            end
            if (e) begin mm = (mm + 1) % 4; ms = 0; end
            else if (mt) ms = (ms + 1) % period(mm);
            mt = nt;
        end
        mbp = b;
        exp_q.push_back({model_led(), 2'(mm), mt});
    endtask

    initial begin : monitor
        logic [10:0] x;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                ncyc++;
                total += 3;
                if (LED !== x[10:3]) begin bad++; $display("FAIL led cyc=%0d got=%h want=%h", ncyc, LED, x[10:3]); end
                if (mode !== x[2:1]) begin bad++; $display("FAIL mode cyc=%0d got=%0d want=%0d", ncyc, mode, x[2:1]); end
                if (tick !== x[0])   begin bad++; $display("FAIL tick cyc=%0d got=%b want=%b", ncyc, tick, x[0]); end
            end
        end
    end

    initial begin : stim
        logic rb, bb, pb;
        int n;
        // reset with the button held: no edge until it falls and rises again
        repeat (3) cyc(1, 1, 0);
        repeat (4) cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 1, 0);            // FILL
        repeat (40) cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 1, 0);            // SHIFT
        repeat (36) cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 1, 0);            // BLINK
        repeat (10) cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 1, 0);            // OFF
        repeat (6) cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 1, 0);            // FILL, then collide an edge with the C0 tick
        n = 0;
        while (!(mm == 1 && model_led() == 8'hC0 && mt) && n < 100) begin cyc(0, 0, 0); n++; end
        if (n >= 100) begin bad++; $display("FAIL collide_setup got=timeout want=tick_at_C0"); end
        cyc(0, 1, 0);
        repeat (10) cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 1, 0);            // BLINK, then pause with a press inside it
        repeat (6) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 1);
        repeat (7) cyc(0, 1, 1);
        repeat (10) cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 1, 0);            // FILL
        cyc(0, 0, 0); cyc(0, 1, 0);            // SHIFT, reset at LED=10
        n = 0;
        while (!(mm == 2 && model_led() == 8'h10) && n < 100) begin cyc(0, 1, 0); n++; end
        if (n >= 100) begin bad++; $display("FAIL reset_setup got=timeout want=led_10"); end
        cyc(1, 1, 0);
        repeat (10) cyc(0, 1, 0);
        // randomized traffic
        rb = 1'b0; bb = 1'b1; pb = 1'b0;
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) bb = ~bb;
            if ($urandom_range(0, 7) == 0) pb = ~pb;
            rb = ($urandom_range(0, 199) == 0);
            cyc(rb, bb, pb);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin @(posedge clk); n++; end
        @(posedge clk); #2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL drain got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
